// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle LEGv8 instruction control unit.
// Latches one instruction per FETCH and decodes it in EXEC. Loads take an
// extra MEM cycle for the register write. An illegal opcode parks the unit
// in HALT until reset.
//
// Optional feature: define CU_RETIRE_COUNT_EN to add the 32-bit `retired`
// output, which counts completed instructions.
//
// Handshake: instruction is captured on a rising clock edge where the unit
// is in FETCH (fetch=1) and instr_valid=1. fetch acts as ready and
// instr_valid as valid. No other back-pressure exists.
module legv8_control_unit #(
    parameter logic [30:0] NOP_WORD = 31'h1FFFC000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    input  logic [4:0]  status,
    output logic        fetch,
    output logic [30:0] controlWord,
    output logic [63:0] K,
    output logic        halted,
`ifdef CU_RETIRE_COUNT_EN
    output logic [31:0] retired,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // ALU function select: {op[2:0], invert B, carry-in}
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_EORI = 10'b1101001000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // Kinds of register-writing ALU instructions sharing one field layout
    localparam logic [1:0] ALU_NONE  = 2'd0;
    localparam logic [1:0] ALU_REG   = 2'd1;
    localparam logic [1:0] ALU_SHIFT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] ir_q;

    // Decoder results
    logic [30:0] dec_word;
    logic [63:0] dec_k;
    logic        dec_legal;
    logic        dec_load;

    logic [1:0]  ps;
    logic [4:0]  da, sa, sb, fs;
    logic        reg_w, ram_w, en_mem, en_alu, en_b, en_pc, sel_b, pc_sel;
    logic [1:0]  alu_kind;
    logic [4:0]  alu_fs;
    logic        hit;

    logic [4:0]  rd, rn, rm;
    assign rd = ir_q[4:0];
    assign rn = ir_q[9:5];
    assign rm = ir_q[20:16];

    // Only the zero flag steers branches; the other status bits are ignored
    logic unused_status;
    assign unused_status = ^status[4:1];

    // State and instruction register; reset aborts any in-flight instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && instr_valid) begin
                ir_q <= instruction;
            end
        end
    end

    // Instruction decode, most specific opcode width first
    always_comb begin
        ps        = 2'b00;
        da        = 5'd31;
        sa        = 5'd31;
        sb        = 5'd31;
        fs        = FS_AND;
        reg_w     = 1'b0;
        ram_w     = 1'b0;
        en_mem    = 1'b0;
        en_alu    = 1'b0;
        en_b      = 1'b0;
        en_pc     = 1'b0;
        sel_b     = 1'b0;
        pc_sel    = 1'b0;
        dec_k     = '0;
        dec_legal = 1'b1;
        dec_load  = 1'b0;
        alu_kind  = ALU_NONE;
        alu_fs    = FS_AND;
        hit       = 1'b1;

        case (ir_q[31:21])
            OP_ADD:  begin alu_kind = ALU_REG;   alu_fs = FS_ADD; end
            OP_SUB:  begin alu_kind = ALU_REG;   alu_fs = FS_SUB; end
            OP_AND:  begin alu_kind = ALU_REG;   alu_fs = FS_AND; end
            OP_ORR:  begin alu_kind = ALU_REG;   alu_fs = FS_OR;  end
            OP_EOR:  begin alu_kind = ALU_REG;   alu_fs = FS_XOR; end
            OP_LSL:  begin alu_kind = ALU_SHIFT; alu_fs = FS_LSL; end
            OP_LSR:  begin alu_kind = ALU_SHIFT; alu_fs = FS_LSR; end
            OP_LDUR: begin
                // Address phase only; the register write happens in MEM
                da       = rd;
                sa       = rn;
                fs       = FS_ADD;
                sel_b    = 1'b1;
                en_mem   = 1'b1;
                dec_k    = {{55{ir_q[20]}}, ir_q[20:12]};
                dec_load = 1'b1;
            end
            OP_STUR: begin
                ps    = 2'b01;
                sa    = rn;
                sb    = rd;
                fs    = FS_ADD;
                sel_b = 1'b1;
                ram_w = 1'b1;
                en_b  = 1'b1;
                dec_k = {{55{ir_q[20]}}, ir_q[20:12]};
            end
            OP_BR: begin
                ps     = 2'b10;
                sa     = rn;
                en_pc  = 1'b1;
                pc_sel = 1'b1;
            end
            default: hit = 1'b0;
        endcase

        if (!hit) begin
            hit = 1'b1;
            case (ir_q[31:22])
                OP_ADDI: begin alu_kind = ALU_IMM; alu_fs = FS_ADD; end
                OP_SUBI: begin alu_kind = ALU_IMM; alu_fs = FS_SUB; end
                OP_ANDI: begin alu_kind = ALU_IMM; alu_fs = FS_AND; end
                OP_ORRI: begin alu_kind = ALU_IMM; alu_fs = FS_OR;  end
                OP_EORI: begin alu_kind = ALU_IMM; alu_fs = FS_XOR; end
                default: hit = 1'b0;
            endcase
        end

        if (!hit) begin
            hit = 1'b1;
            case (ir_q[31:24])
                OP_CBZ, OP_CBNZ: begin
                    // Rt OR XZR puts Rt on the ALU output so Z reflects Rt==0.
                    // Opcode bit 24 distinguishes CBNZ and inverts the test.
                    sb     = rd;
                    fs     = FS_OR;
                    en_alu = 1'b1;
                    dec_k  = {{45{ir_q[23]}}, ir_q[23:5]};
                    ps     = (status[0] ^ ir_q[24]) ? 2'b11 : 2'b01;
                end
                default: hit = 1'b0;
            endcase
        end

        if (!hit) begin
            if (ir_q[31:26] == OP_B) begin
                ps    = 2'b11;
                dec_k = {{38{ir_q[25]}}, ir_q[25:0]};
            end else begin
                dec_legal = 1'b0;
            end
        end

        if (alu_kind != ALU_NONE) begin
            ps     = 2'b01;
            da     = rd;
            sa     = rn;
            fs     = alu_fs;
            reg_w  = 1'b1;
            en_alu = 1'b1;
            case (alu_kind)
                ALU_REG: sb = rm;
                ALU_SHIFT: begin
                    sb    = rm;
                    sel_b = 1'b1;
                    dec_k = {58'd0, ir_q[15:10]};
                end
                ALU_IMM: begin
                    sb    = 5'd31;
                    sel_b = 1'b1;
                    dec_k = {52'd0, ir_q[21:10]};
                end
                default: ;
            endcase
        end

        dec_word = {ps, da, sa, sb, fs, reg_w, ram_w, en_mem, en_alu,
                    en_b, en_pc, sel_b, pc_sel, 1'b0};
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (instr_valid) state_d = S_EXEC;
            S_EXEC: begin
                if (!dec_legal)    state_d = S_HALT;
                else if (dec_load) state_d = S_MEM;
                else               state_d = S_FETCH;
            end
            S_MEM:   state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    // Datapath outputs; reset blanks the word so an aborted load never writes
    always_comb begin
        controlWord = NOP_WORD;
        K           = '0;
        if (!reset) begin
            case (state_q)
                S_EXEC: begin
                    if (dec_legal) begin
                        controlWord = dec_word;
                        K           = dec_k;
                    end
                end
                S_MEM: begin
                    controlWord = {2'b01, dec_word[28:9], 1'b1, dec_word[7:0]};
                    K           = dec_k;
                end
                default: ;
            endcase
        end
    end

    assign fetch     = (state_q == S_FETCH);
    assign halted    = (state_q == S_HALT);
    assign dbg_state = state_q;

`ifdef CU_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    // Count instructions completing back to FETCH; wraps naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
        end else if ((state_q == S_EXEC || state_q == S_MEM) && state_d == S_FETCH) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: a vector table for single-cycle
// instructions plus hand-written sequences for LDUR, reset abort and HALT.
module tb_legv8_control_unit;

  localparam logic [30:0] NOP = 31'h1FFFC000;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // flags = {regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, selB, PCsel}
  localparam logic [7:0] F_ALU_R  = 8'b1001_0000;
  localparam logic [7:0] F_ALU_I  = 8'b1001_0010;
  localparam logic [7:0] F_STUR   = 8'b0100_1010;
  localparam logic [7:0] F_CB     = 8'b0001_0000;
  localparam logic [7:0] F_BR     = 8'b0000_0101;
  localparam logic [7:0] F_LD_EX  = 8'b0010_0010;
  localparam logic [7:0] F_LD_MEM = 8'b1010_0010;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [4:0]  status;
  logic        fetch;
  logic [30:0] controlWord;
  logic [63:0] K;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired;
  int          exp_retired;
`endif

  int total;
  int bad;

  typedef struct {
    logic [31:0] instr;
    logic        st0;
    logic [30:0] exp_cw;
    logic [63:0] exp_k;
  } vec_t;

  vec_t vecs[$];

  legv8_control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .status      (status),
    .fetch       (fetch),
    .controlWord (controlWord),
    .K           (K),
    .halted      (halted),
`ifdef CU_RETIRE_COUNT_EN
    .retired     (retired),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // encoders for stimulus and packer for expected words
  function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [5:0] sh,
                                        logic [4:0] rn, logic [4:0] rd);
    return {op, rm, sh, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(logic [9:0] op, logic [11:0] imm, logic [4:0] rn,
                                        logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm, logic [4:0] rn,
                                        logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] imm, logic [4:0] rt);
    return {op, imm, rt};
  endfunction

  function automatic logic [31:0] enc_b(logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic logic [30:0] cw(logic [1:0] ps, logic [4:0] da, logic [4:0] sa,
                                     logic [4:0] sb, logic [4:0] fs, logic [7:0] flags);
    return {ps, da, sa, sb, fs, flags, 1'b0};
  endfunction

  // scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: present one instruction for a single FETCH cycle, then scramble the bus
  task automatic issue(input logic [31:0] instr, input logic st0);
    @(negedge clock);
    instruction = instr;
    instr_valid = 1'b1;
    status = {4'b1010, st0};
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instruction = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
`ifdef CU_RETIRE_COUNT_EN
    exp_retired = 0;
`endif
  endtask

  task automatic run_ldur(input string tag);
    issue(enc_d(11'b11111000010, 9'h1F8, 5'd7, 5'd0), 1'b0);
    @(negedge clock);
    chk({tag, "_exec_cw"}, controlWord, cw(2'b00, 5'd0, 5'd7, 5'd31, 5'b01000, F_LD_EX));
    chk({tag, "_exec_k"}, K, 64'hFFFF_FFFF_FFFF_FFF8);
    chk({tag, "_exec_state"}, dbg_state, ST_EXEC);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_mem_cw"}, controlWord, cw(2'b01, 5'd0, 5'd7, 5'd31, 5'b01000, F_LD_MEM));
    chk({tag, "_mem_k"}, K, 64'hFFFF_FFFF_FFFF_FFF8);
    chk({tag, "_mem_fetch"}, fetch, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_after_state"}, dbg_state, ST_FETCH);
    chk({tag, "_after_cw"}, controlWord, NOP);
`ifdef CU_RETIRE_COUNT_EN
    exp_retired++;
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    status = '0;
`ifdef CU_RETIRE_COUNT_EN
    exp_retired = 0;
`endif

    vecs.push_back('{32'h910063E5, 1'b0, 31'h25FFD124, 64'd24});
    vecs.push_back('{enc_r(11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1), 1'b0,
                     cw(2'b01, 5'd1, 5'd2, 5'd3, 5'b01000, F_ALU_R), 64'd0});
    vecs.push_back('{enc_r(11'b11001011000, 5'd6, 6'd0, 5'd5, 5'd4), 1'b0,
                     cw(2'b01, 5'd4, 5'd5, 5'd6, 5'b01011, F_ALU_R), 64'd0});
    vecs.push_back('{enc_r(11'b10001010000, 5'd9, 6'd0, 5'd8, 5'd7), 1'b0,
                     cw(2'b01, 5'd7, 5'd8, 5'd9, 5'b00000, F_ALU_R), 64'd0});
    vecs.push_back('{enc_r(11'b10101010000, 5'd12, 6'd0, 5'd11, 5'd10), 1'b0,
                     cw(2'b01, 5'd10, 5'd11, 5'd12, 5'b00100, F_ALU_R), 64'd0});
    vecs.push_back('{enc_r(11'b11001010000, 5'd15, 6'd0, 5'd14, 5'd13), 1'b0,
                     cw(2'b01, 5'd13, 5'd14, 5'd15, 5'b01100, F_ALU_R), 64'd0});
    vecs.push_back('{enc_r(11'b11010011011, 5'd0, 6'd5, 5'd2, 5'd1), 1'b0,
                     cw(2'b01, 5'd1, 5'd2, 5'd0, 5'b10000, F_ALU_I), 64'd5});
    vecs.push_back('{enc_r(11'b11010011010, 5'd0, 6'd63, 5'd4, 5'd3), 1'b0,
                     cw(2'b01, 5'd3, 5'd4, 5'd0, 5'b10100, F_ALU_I), 64'd63});
    vecs.push_back('{enc_i(10'b1101000100, 12'hFFF, 5'd3, 5'd2), 1'b0,
                     cw(2'b01, 5'd2, 5'd3, 5'd31, 5'b01011, F_ALU_I), 64'd4095});
    vecs.push_back('{enc_i(10'b1001001000, 12'h0F0, 5'd7, 5'd6), 1'b0,
                     cw(2'b01, 5'd6, 5'd7, 5'd31, 5'b00000, F_ALU_I), 64'h0F0});
    vecs.push_back('{enc_i(10'b1011001000, 12'h001, 5'd9, 5'd8), 1'b0,
                     cw(2'b01, 5'd8, 5'd9, 5'd31, 5'b00100, F_ALU_I), 64'd1});
    vecs.push_back('{enc_i(10'b1101001000, 12'h800, 5'd12, 5'd11), 1'b0,
                     cw(2'b01, 5'd11, 5'd12, 5'd31, 5'b01100, F_ALU_I), 64'h800});
    vecs.push_back('{enc_d(11'b11111000000, 9'd16, 5'd10, 5'd9), 1'b0,
                     cw(2'b01, 5'd31, 5'd10, 5'd9, 5'b01000, F_STUR), 64'd16});
    vecs.push_back('{enc_d(11'b11111000000, 9'h100, 5'd2, 5'd1), 1'b1,
                     cw(2'b01, 5'd31, 5'd2, 5'd1, 5'b01000, F_STUR), 64'hFFFF_FFFF_FFFF_FF00});
    vecs.push_back('{enc_b(26'h3FF_FFFF), 1'b0,
                     cw(2'b11, 5'd31, 5'd31, 5'd31, 5'b00000, 8'h00), 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{enc_b(26'd100), 1'b1,
                     cw(2'b11, 5'd31, 5'd31, 5'd31, 5'b00000, 8'h00), 64'd100});
    vecs.push_back('{enc_cb(8'b10110100, 19'h7FFFD, 5'd3), 1'b1,
                     cw(2'b11, 5'd31, 5'd31, 5'd3, 5'b00100, F_CB), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{enc_cb(8'b10110100, 19'h7FFFD, 5'd3), 1'b0,
                     cw(2'b01, 5'd31, 5'd31, 5'd3, 5'b00100, F_CB), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{enc_cb(8'b10110101, 19'd5, 5'd3), 1'b0,
                     cw(2'b11, 5'd31, 5'd31, 5'd3, 5'b00100, F_CB), 64'd5});
    vecs.push_back('{enc_cb(8'b10110101, 19'd5, 5'd3), 1'b1,
                     cw(2'b01, 5'd31, 5'd31, 5'd3, 5'b00100, F_CB), 64'd5});
    vecs.push_back('{enc_r(11'b11010110000, 5'd0, 6'd0, 5'd30, 5'd0), 1'b0,
                     cw(2'b10, 5'd31, 5'd30, 5'd31, 5'b00000, F_BR), 64'd0});

    // reset held two cycles, then idle in FETCH
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_fetch", fetch, 1'b1);
    chk("rst_cw", controlWord, NOP);
    chk("rst_k", K, 64'd0);
    chk("rst_halted", halted, 1'b0);
`ifdef CU_RETIRE_COUNT_EN
    chk("rst_retired", retired, 32'd0);
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("idle_state", dbg_state, ST_FETCH);
    chk("idle_cw", controlWord, NOP);

    // table-driven single-pass instructions
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].instr, vecs[i].st0);
      @(negedge clock);
      chk($sformatf("v%0d_cw", i), controlWord, vecs[i].exp_cw);
      chk($sformatf("v%0d_k", i), K, vecs[i].exp_k);
      chk($sformatf("v%0d_exec_fetch", i), fetch, 1'b0);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("v%0d_back_fetch", i), fetch, 1'b1);
      chk($sformatf("v%0d_back_cw", i), controlWord, NOP);
`ifdef CU_RETIRE_COUNT_EN
      exp_retired++;
`endif
    end
`ifdef CU_RETIRE_COUNT_EN
    chk("table_retired", retired, exp_retired);
`endif

    // LDUR two-cycle sequence
    run_ldur("ldur");

`ifdef CU_RETIRE_COUNT_EN
    // three ALU instructions plus one load after a fresh reset
    do_reset(1);
    for (int i = 1; i < 4; i++) begin
      issue(vecs[i].instr, 1'b0);
      @(posedge clock);
      exp_retired++;
    end
    run_ldur("ret_ldur");
    @(negedge clock);
    chk("retired_four", retired, 32'd4);
    chk("retired_model", retired, exp_retired);
`endif

    // reset during MEM aborts the load write
    issue(enc_d(11'b11111000010, 9'h1F8, 5'd7, 5'd0), 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("abort_in_mem", dbg_state, ST_MEM);
    reset = 1'b1;
    #1;
    chk("abort_regw", controlWord[8], 1'b0);
    chk("abort_cw", controlWord, NOP);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
`ifdef CU_RETIRE_COUNT_EN
    exp_retired = 0;
`endif
    chk("abort_state", dbg_state, ST_FETCH);
    chk("abort_cw_after", controlWord, NOP);
`ifdef CU_RETIRE_COUNT_EN
    chk("abort_retired", retired, 32'd0);
`endif

    // illegal all-zero word: EXEC, then sticky HALT
    issue(32'h0000_0000, 1'b0);
    @(negedge clock);
    chk("ill_exec_state", dbg_state, ST_EXEC);
    chk("ill_exec_cw", controlWord, NOP);
    chk("ill_exec_halted", halted, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      instruction = vecs[1].instr;
      instr_valid = 1'b1;
      chk($sformatf("halt%0d_halted", c), halted, 1'b1);
      chk($sformatf("halt%0d_cw", c), controlWord, NOP);
      chk($sformatf("halt%0d_fetch", c), fetch, 1'b0);
      chk($sformatf("halt%0d_k", c), K, 64'd0);
    end
`ifdef CU_RETIRE_COUNT_EN
    chk("halt_retired", retired, 32'd0);
`endif
    do_reset(1);
    chk("halt_clr_halted", halted, 1'b0);
    chk("halt_clr_fetch", fetch, 1'b1);
    chk("halt_clr_state", dbg_state, ST_FETCH);

    // all-ones word is also undecodable
    issue(32'hFFFF_FFFF, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("ill2_halted", halted, 1'b1);
    do_reset(1);

    // a normal instruction still works after leaving HALT
    issue(vecs[0].instr, 1'b0);
    @(negedge clock);
    chk("post_halt_cw", controlWord, vecs[0].exp_cw);
    chk("post_halt_k", K, vecs[0].exp_k);
    @(posedge clock);
    @(negedge clock);
    chk("post_halt_fetch", fetch, 1'b1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
